serial_comparator: RTL
======================

Name: serial_comparator

Overview:
- Sequential counterpart of the team's parallel 4-bit magnitude comparator.
- Accepts two WIDTH-bit operands through a valid/ready handshake and compares them one bit per cycle, MSB first.
- Exits early on the first differing bit and presents eq/gr/le plus a one-cycle done pulse.
- Used where area matters more than latency. The parallel comparator serves as the golden model in verification.

Parameters:
- WIDTH, 4: operand width in bits; legal values 2..32.
- EARLY_EXIT, 1: 1 = finish on the first differing bit; 0 = always scan all WIDTH bits (constant latency).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands a/b valid this cycle
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- busy  out  1  comparison in progress (SCAN state)
- done  out  1  one-cycle pulse; eq/gr/le updated this cycle
- eq  out  1  a == b
- gr  out  1  a > b (unsigned)
- le  out  1  a < b (unsigned; name kept for parity with the parallel comparator)

Behaviour:
- Reset: rst sampled high at a clk edge forces state=IDLE, in_ready=1, busy=0, done=0, eq=0, gr=0, le=0. The shift registers and bit counter are cleared to 0.
- Reset mid-SCAN aborts the operation: no done pulse and results stay 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch a→sa and b→sb, load cnt=WIDTH-1, go to SCAN.
  - in_valid while not in IDLE is ignored; there is no queueing.
- SCAN, each cycle, with busy=1:
  - Compare sa[WIDTH-1] with sb[WIDTH-1], then shift both left by 1 and decrement cnt.
  - If the bits differ, record the decision: gt_r = sa_msb & ~sb_msb, lt_r = ~sa_msb & sb_msb.
  - With EARLY_EXIT=1, go to DONE in the same cycle a difference is found.
  - Otherwise go to DONE when cnt==0.
  - Once a decision is recorded, later bits must not change it (sticky).
- DONE, exactly one cycle:
  - done=1.
  - eq, gr, le registered from the decision: eq = ~gt_r & ~lt_r.
  - Return to IDLE.
- Result outputs hold their value until the next DONE or reset. Exactly one of eq/gr/le is high after the first completed compare.
- Latency is counted from the accept edge to the cycle in which done is high.
  - EARLY_EXIT=1: k+1 cycles, where k is the 1-based index (from the MSB) of the first differing bit; WIDTH+1 if the operands are equal.
  - EARLY_EXIT=0: always WIDTH+1.
- Back-to-back: in_ready returns high in the cycle after done. Minimum throughput is one compare per WIDTH+2 cycles.
- Operands are latched on accept; a and b may change freely afterwards without affecting the result.
- Boundary cases:
  - Operands 0 vs 0 and all-ones vs all-ones scan all bits and give eq=1.
  - A difference only in the LSB takes full WIDTH+1 latency, with no off-by-one.
  - X on a/b while in_valid=0 must not propagate.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum typedef cmp_state_t {IDLE, SCAN, DONE};
  - the 3-bit result encoding constants CMP_EQ=3'b100, CMP_GR=3'b010, CMP_LE=3'b001, so that the serial and parallel comparators share one encoding for the testbench.
- One natural sub-module, serial_cmp_bitcell: a 1-bit MSB comparator holding the sticky gt/lt decision flags, with ports clk, rst, clr, en, abit, bbit, gt, lt.
- The top level holds the FSM, shift registers and counter.

Test Plan:
- Reset, then a=4'd9, b=4'd9 → done after 5 cycles; eq=1, gr=0, le=0.
- a=4'd12 (1100), b=4'd3 (0011) with EARLY_EXIT=1 → done 2 cycles after accept; gr=1, eq=0, le=0.
- a=4'd6, b=4'd7 (differ in LSB only) → done after 5 cycles; le=1. With EARLY_EXIT=0, a=4'd8, b=4'd0 → also 5 cycles; gr=1.
- Change a/b and hold in_valid=1 during SCAN → in_ready=0, result reflects the originally latched operands, and only one compare is accepted.
- Assert rst for 1 cycle in the 2nd SCAN cycle of a=4'd15, b=4'd0 → no done pulse; eq/gr/le=0 and in_ready=1 on the next cycle.
- Random regression, 10 000 pairs × WIDTH∈{4,8}: results match the parallel comparator (a==b, a>b, a<b), latency matches the formula, and the eq/gr/le outputs are one-hot after every done.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM states and result encoding for the serial and parallel comparators
package cmp_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;

    // One-hot {eq, gr, le} codes shared with the parallel comparator
    localparam logic [2:0] CMP_EQ = 3'b100;
    localparam logic [2:0] CMP_GR = 3'b010;
    localparam logic [2:0] CMP_LE = 3'b001;

    // Map the sticky gt/lt decision onto the shared result code
    function automatic logic [2:0] cmp_encode(input logic gt, input logic lt);
        return gt ? CMP_GR : lt ? CMP_LE : CMP_EQ;
    endfunction

endpackage

// File: rtl/serial_cmp_bitcell.sv
// serial_cmp_bitcell: 1-bit MSB comparator holding the sticky gt/lt decision
module serial_cmp_bitcell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic abit,
    input  logic bbit,
    output logic gt,
    output logic lt
);

    // Record the first differing bit; later bits cannot override a decision
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            gt <= 1'b0;
            lt <= 1'b0;
        end else if (en && !gt && !lt) begin
            gt <= abit & ~bbit;
            lt <= ~abit & bbit;
        end
    end

endmodule

// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial MSB-first magnitude comparator with valid/ready input
module serial_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gr,
    output logic             le
);

    localparam int CW = $clog2(WIDTH);

    cmp_state_t       state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic [2:0]       res;
    logic             gt, lt, accept, diff, scan;

    assign accept = in_valid & in_ready;
    assign scan   = (state == SCAN);
    assign diff   = sa[WIDTH-1] ^ sb[WIDTH-1];

    serial_cmp_bitcell u_cell (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (scan),
        .abit (sa[WIDTH-1]),
        .bbit (sb[WIDTH-1]),
        .gt   (gt),
        .lt   (lt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake/status outputs
    always_comb begin
        state_nx = state;
        in_ready = (state == IDLE);
        busy     = scan;
        done     = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nx = SCAN;
            SCAN:    if ((EARLY_EXIT && diff) || cnt == '0) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand shift registers and remaining-bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            cnt <= CW'(WIDTH - 1);
        end else if (scan) begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt - CW'(1);
        end
    end

    // Hold the last result so it survives the next accept clearing the bitcell
    always_ff @(posedge clk) begin
        if (rst)       res <= '0;
        else if (done) res <= cmp_encode(gt, lt);
    end

    // Results come straight from the decision during DONE, then from the held copy
    assign {eq, gr, le} = done ? cmp_encode(gt, lt) : res;

endmodule
